grey_chain: RTL
===============

Name: grey_chain

Overview:
- Parametrised successor of the prescaled decade-counter cascade: a prescaler plus a chain of pDIGITS Johnson-coded ("ring grey") digits, each of modulus 2*pWIDTH.
- Fully synchronous in one clock domain: digits advance on clock-enable carries, with no ripple-derived clocks.
- Adds run enable, up/down counting, parallel load with code sanitising, a step strobe and a full-chain wrap pulse.
- Drives display/debug outputs at the top level.

Parameters:
- pCOUNT, 1000, prescaler period in i_clk cycles (>=1); one step every pCOUNT enabled cycles.
- pDIGITS, 3, number of cascaded digits (>=1); digit 0 is least significant.
- pWIDTH, 5, bits per Johnson digit (>=2); digit modulus is 2*pWIDTH (5 gives decade).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_en  in  1  run enable; prescaler and digits hold when low.
- i_dir  in  1  1=count up, 0=count down; sampled at each step.
- i_load  in  1  parallel load strobe.
- i_load_val  in  pDIGITS*pWIDTH  load value; digit k occupies bits [k*pWIDTH +: pWIDTH].
- o_cnt  out  pDIGITS*pWIDTH  current digits, same packing as i_load_val.
- o_step  out  1  high in the cycle a step is applied.
- o_wrap  out  1  one-cycle pulse when the whole chain wraps.

Behaviour:
- Reset is one clock, synchronous and active-high (i_clk, i_rst).
- Reset stretch: internal reset w_rst is held for 8 cycles after the last cycle i_rst is sampled high, via an 8-bit shift register preset to all ones.
- While w_rst is high: prescaler=0, all digits=0, o_step=0, o_wrap=0.
- Reset values: o_cnt=0, o_step=0, o_wrap=0.
- Priority per cycle: w_rst > i_load > step > hold.
- Prescaler: counts 0..pCOUNT-1 only while i_en=1 and i_load=0.
  - o_step is combinational: i_en & ~i_load & ~w_rst & (presc==pCOUNT-1).
  - On a step the prescaler returns to 0. For pCOUNT=1, o_step=i_en every cycle.
- Johnson step rules:
  - up: next = {d[W-2:0], ~d[W-1]}.
  - down: next = {~d[0], d[W-1:1]}.
  - Up sequence for W=5: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, back to 00000.
- Carry/borrow:
  - Digit 0 advances on o_step.
  - Digit k advances when o_step is high and every lower digit is at its terminal code.
  - Terminal code is 1 followed by W-1 zeros when up, and all zeros when down.
  - A digit at terminal wraps; exactly one bit of each advancing digit toggles.
- o_wrap:
  - Registered pulse, high for one cycle, coincident with the first cycle the wrapped value is visible on o_cnt.
  - Up wrap: all digits terminal-up, giving all zeros.
  - Down wrap: all zeros, giving all digits 1 followed by zeros (max).
- Load:
  - On i_load=1, o_cnt takes i_load_val on the next edge and the prescaler clears to 0. Load is independent of i_en.
  - Any digit whose code is not a valid Johnson state is loaded as 00000.
  - Valid means at most one bit transition along d[W-1:0], i.e. popcount over the adjacent-pair XORs <= 1.
  - No o_wrap on load. i_load overrides a coincident prescaler terminal.
- i_dir change: takes effect at the next step, and the terminal test uses the i_dir value current at that step.
- i_en low mid-period: prescaler and digits freeze. Counting resumes from the same prescaler value.
- i_rst mid-operation: state clears on the next edge regardless of load or step.
- Width rules:
  - Prescaler width is $clog2(pCOUNT), minimum 1.
  - No arithmetic on digits; all digit logic is shift/invert only.

Decomposition:
- Package grey_chain_pkg holds:
  - functions johnson_next(d, dir), johnson_valid(d) and johnson_terminal(d, dir), parametrised by width via a W-bit max localparam (MAX_W=16) with a width argument;
  - localparam RST_STRETCH=8.
- Sub-module grey_digit, instantiated pDIGITS times in a generate loop:
  - inputs i_clk, i_rst (stretched), i_adv, i_dir, i_load, i_load_val;
  - outputs o_cnt, o_term.
- Top holds the reset stretcher, prescaler, carry AND-chain and wrap register.

Test Plan:
- Reset stretch (pCOUNT=4): pulse i_rst for 1 cycle with i_en=1 -> o_cnt=0 and no o_step for 8 cycles after release; first o_step on cycle 8+4.
- Up counting (pCOUNT=1, pDIGITS=2): i_en=1, i_dir=1 for 99 cycles -> o_cnt={10000,10000}; next step -> o_cnt=0, o_wrap=1 for exactly one cycle.
- Down wrap (pCOUNT=1): from reset, i_dir=0, one step -> every digit = 10000, o_wrap=1; second step -> digit0 = 11000, digit1 unchanged.
- Load sanitising: i_load with digit0=00101 (invalid) and digit1=00111 -> o_cnt digit0=00000, digit1=00111; prescaler=0; no o_wrap.
- Enable/priority (pCOUNT=3): drop i_en at prescaler=1 for 5 cycles -> no change; i_load coincident with terminal -> load wins, o_step=0.
- Single-bit property: random i_dir/i_en over 10k cycles -> each digit changes at most one bit per cycle; the scoreboard decimal value tracks ±1 per o_step, mod 10^pDIGITS.

Source files
------------

// File: rtl/grey_chain_pkg.sv
// Shared constants and Johnson-code helpers for the grey_chain digit cascade.
// Helpers work on a MAX_W-bit container; the live digit width is passed in as w.
package grey_chain_pkg;

  localparam int MAX_W       = 16;
  localparam int RST_STRETCH = 8;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    logic [MAX_W-1:0] m;
    m = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
      else       m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] msb_onehot(input int w);
    logic [MAX_W-1:0] m;
    m = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) m[i] = 1'b1;
      else            m[i] = 1'b0;
    end
    return m;
  endfunction

  // Shift/invert only: up feeds ~msb into bit 0, down feeds ~lsb into the msb.
  function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] d,
                                                     input logic dir, input int w);
    logic [MAX_W-1:0] dm;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] r;
    dm  = d & width_mask(w);
    top = msb_onehot(w);
    if (dir) begin
      r = ((dm << 1'b1) & width_mask(w)) | {{(MAX_W-1){1'b0}}, ~(|(dm & top))};
    end else begin
      r = (dm >> 1'b1) | (dm[0] ? {MAX_W{1'b0}} : top);
    end
    return r;
  endfunction

  function automatic logic johnson_valid(input logic [MAX_W-1:0] d, input int w);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if ((i < w - 1) && (d[i] != d[i+1])) n = n + 5'd1;
      else                                 n = n;
    end
    return (n <= 5'd1);
  endfunction

  function automatic logic johnson_terminal(input logic [MAX_W-1:0] d,
                                            input logic dir, input int w);
    logic [MAX_W-1:0] dm;
    dm = d & width_mask(w);
    return dir ? (dm == msb_onehot(w)) : (dm == {MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/grey_chain_digit.sv
// One Johnson-coded digit: load with sanitising, advance on carry enable,
// and report whether it sits at the terminal code for the current direction.
module grey_digit
  import grey_chain_pkg::*;
#(
  parameter int pWIDTH = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  input  logic              i_dir,
  input  logic              i_load,
  input  logic [pWIDTH-1:0] i_load_val,
  output logic [pWIDTH-1:0] o_cnt,
  output logic              o_term
);

  logic [pWIDTH-1:0] cnt_r;
  logic [MAX_W-1:0]  cnt_ext_s;
  logic [MAX_W-1:0]  load_ext_s;
  logic [MAX_W-1:0]  next_ext_s;
  logic              load_ok_s;

  assign cnt_ext_s  = MAX_W'(cnt_r);
  assign load_ext_s = MAX_W'(i_load_val);
  assign next_ext_s = johnson_next(cnt_ext_s, i_dir, pWIDTH);
  assign load_ok_s  = johnson_valid(load_ext_s, pWIDTH);
  assign o_term     = johnson_terminal(cnt_ext_s, i_dir, pWIDTH);
  assign o_cnt      = cnt_r;

  // Digit register: reset > load (illegal codes become zero) > advance > hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {pWIDTH{1'b0}};
    end else if (i_load) begin
      cnt_r <= load_ok_s ? i_load_val : {pWIDTH{1'b0}};
    end else if (i_adv) begin
      cnt_r <= next_ext_s[pWIDTH-1:0];
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/grey_chain.sv
// Prescaled cascade of Johnson digits with run enable, up/down, sanitised load,
// stretched synchronous reset and a registered full-chain wrap pulse.
module grey_chain
  import grey_chain_pkg::*;
#(
  parameter int pCOUNT  = 1000,
  parameter int pDIGITS = 3,
  parameter int pWIDTH  = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_dir,
  input  logic                      i_load,
  input  logic [pDIGITS*pWIDTH-1:0] i_load_val,
  output logic [pDIGITS*pWIDTH-1:0] o_cnt,
  output logic                      o_step,
  output logic                      o_wrap
);

  localparam int              PW         = (pCOUNT > 1) ? $clog2(pCOUNT) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(pCOUNT - 1);

  logic [RST_STRETCH-1:0] rst_sr_r;
  logic                   w_rst_s;
  logic [PW-1:0]          presc_r;
  logic                   step_s;
  logic [pDIGITS-1:0]     term_s;
  logic [pDIGITS:0]       chain_s;
  logic                   wrap_r;

  // Reset stretcher: ones shift out so w_rst stays high 8 cycles past i_rst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_sr_r <= {RST_STRETCH{1'b1}};
    end else begin
      rst_sr_r <= {rst_sr_r[RST_STRETCH-2:0], 1'b0};
    end
  end

  assign w_rst_s = i_rst | (|rst_sr_r);
  assign step_s  = i_en & ~i_load & ~w_rst_s & (presc_r == PRESC_LAST);
  assign o_step  = step_s;

  // Prescaler: a load or a step restarts the period; low enable freezes it.
  always_ff @(posedge i_clk) begin
    if (w_rst_s) begin
      presc_r <= {PW{1'b0}};
    end else if (i_load) begin
      presc_r <= {PW{1'b0}};
    end else if (step_s) begin
      presc_r <= {PW{1'b0}};
    end else if (i_en) begin
      presc_r <= presc_r + PW'(1'b1);
    end else begin
      presc_r <= presc_r;
    end
  end

  assign chain_s[0] = step_s;

  genvar k;
  generate
    for (k = 0; k < pDIGITS; k++) begin : g_digit
      grey_digit #(.pWIDTH(pWIDTH)) u_digit (
        .i_clk      (i_clk),
        .i_rst      (w_rst_s),
        .i_adv      (chain_s[k]),
        .i_dir      (i_dir),
        .i_load     (i_load),
        .i_load_val (i_load_val[k*pWIDTH +: pWIDTH]),
        .o_cnt      (o_cnt[k*pWIDTH +: pWIDTH]),
        .o_term     (term_s[k])
      );
      assign chain_s[k+1] = chain_s[k] & term_s[k];
    end
  endgenerate

  // Wrap pulse lines up with the first cycle the wrapped value is on o_cnt.
  always_ff @(posedge i_clk) begin
    if (w_rst_s) begin
      wrap_r <= 1'b0;
    end else if (i_load) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= chain_s[pDIGITS];
    end
  end

  assign o_wrap = wrap_r;

endmodule
